// File: rtl/sample_stream_pkg.sv
// rtl/sample_stream_pkg.sv - shared types and helpers for the sample stream serialiser
package sample_stream_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD_OUT = 2'd1,
        SEND     = 2'd2
    } ser_state_t;

    localparam logic [7:0] ERR_SAT = 8'hFF;

    function automatic logic nbytes_valid(input int unsigned nbytes, input int unsigned word_bytes);
        return (nbytes != 0) && (nbytes <= word_bytes);
    endfunction

endpackage

// File: rtl/sample_word_fifo.sv
// rtl/sample_word_fifo.sv - synchronous word FIFO holding {nbytes, data} entries
module sample_word_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/sample_stream_serializer.sv
// rtl/sample_stream_serializer.sv - buffers words and serialises them into a byte stream
module sample_stream_serializer
    import sample_stream_pkg::*;
#(
    parameter int unsigned WORD_BYTES = 4,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter bit          LSB_FIRST  = 1'b1
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              word_in_valid,
    output logic                              word_in_ready,
    input  logic [8*WORD_BYTES-1:0]           word_in_data,
    input  logic [$clog2(WORD_BYTES+1)-1:0]   word_in_nbytes,
    output logic                              stream_out_valid,
    input  logic                              stream_out_ready,
    output logic [7:0]                        stream_out_data,
    output logic                              stream_out_last,
    output logic [31:0]                       byte_count,
    output logic [7:0]                        err_count
);

    localparam int unsigned DW  = 8 * WORD_BYTES;
    localparam int unsigned NBW = $clog2(WORD_BYTES + 1);
    localparam int unsigned FW  = NBW + DW;

    // In MSB-first mode the word is pre-aligned so its top valid byte sits at the MSB end.
    function automatic logic [DW-1:0] align_word(input logic [DW-1:0] d, input logic [NBW-1:0] n);
        if (LSB_FIRST) return d;
        return d << {NBW'(WORD_BYTES) - n, 3'b000};
    endfunction

    function automatic byte_t first_byte(input logic [DW-1:0] w);
        return LSB_FIRST ? w[7:0] : w[DW-1 -: 8];
    endfunction

    function automatic logic [DW-1:0] drop_byte(input logic [DW-1:0] w);
        return LSB_FIRST ? (w >> 8) : (w << 8);
    endfunction

    ser_state_t     state;
    logic           ready_en;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_push;
    logic           fifo_pop;
    logic [FW-1:0]  fifo_dout;
    logic [DW-1:0]  head_data;
    logic [NBW-1:0] head_nbytes;
    logic [DW-1:0]  head_aligned;
    logic [DW-1:0]  shift_reg;
    logic [NBW-1:0] remaining;
    logic           in_fire;
    logic           in_ok;
    logic           beat_fire;
    logic           word_done;

    assign word_in_ready = ready_en && !fifo_full;
    assign in_fire       = word_in_valid && word_in_ready;
    assign in_ok         = nbytes_valid(32'(word_in_nbytes), WORD_BYTES);
    assign fifo_push     = in_fire && in_ok;

    assign {head_nbytes, head_data} = fifo_dout;
    assign head_aligned = align_word(head_data, head_nbytes);

    assign beat_fire = (state == SEND) && stream_out_valid && stream_out_ready;
    assign word_done = beat_fire && (remaining == NBW'(1));
    assign fifo_pop  = !fifo_empty && ((state == IDLE) || word_done);

    sample_word_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .din     ({word_in_nbytes, word_in_data}),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            ready_en         <= 1'b0;
            shift_reg        <= '0;
            remaining        <= '0;
            stream_out_valid <= 1'b0;
            stream_out_data  <= '0;
            stream_out_last  <= 1'b0;
            byte_count       <= '0;
            err_count        <= '0;
        end else begin
            ready_en <= 1'b1;
            if (in_fire && !in_ok && (err_count != ERR_SAT)) err_count <= err_count + 8'd1;

            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        shift_reg <= head_aligned;
                        remaining <= head_nbytes;
                        state     <= LOAD_OUT;
                    end
                end
                LOAD_OUT: begin
                    stream_out_valid <= 1'b1;
                    stream_out_data  <= first_byte(shift_reg);
                    stream_out_last  <= (remaining == NBW'(1));
                    shift_reg        <= drop_byte(shift_reg);
                    state            <= SEND;
                end
                SEND: begin
                    if (beat_fire) begin
                        byte_count <= byte_count + 32'd1;
                        if (remaining == NBW'(1)) begin
                            // Chain straight into the next queued word so there is no bubble.
                            if (!fifo_empty) begin
                                stream_out_data <= first_byte(head_aligned);
                                stream_out_last <= (head_nbytes == NBW'(1));
                                shift_reg       <= drop_byte(head_aligned);
                                remaining       <= head_nbytes;
                            end else begin
                                stream_out_valid <= 1'b0;
                                stream_out_last  <= 1'b0;
                                remaining        <= '0;
                                state            <= IDLE;
                            end
                        end else begin
                            stream_out_data <= first_byte(shift_reg);
                            stream_out_last <= (remaining == NBW'(2));
                            shift_reg       <= drop_byte(shift_reg);
                            remaining       <= remaining - 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sample_stream_serializer.sv
// tb/tb_sample_stream_serializer.sv - self-checking bench for sample_stream_serializer
module tb_sample_stream_serializer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        word_in_valid;
    logic [31:0] word_in_data;
    logic [2:0]  word_in_nbytes;
    logic        stream_out_ready;

    logic        ready_a, valid_a, last_a, ready_b, valid_b, last_b;
    logic [7:0]  data_a, data_b, ec_a, ec_b;
    logic [31:0] bc_a, bc_b;

    int          pass_count  = 0;
    int          check_count = 0;
    logic [8:0]  q_lsb[$];
    logic [8:0]  q_msb[$];
    int          beats = 0;
    longint      bytes_model = 0;
    int          err_model = 0;
    bit          rdy_rand = 1'b0;
    logic        rdy_const = 1'b1;
    bit          prev_stall[2];
    logic [7:0]  prev_data[2];
    logic        prev_last[2];

    always #5 clk = ~clk;

    sample_stream_serializer #(.WORD_BYTES(4), .FIFO_DEPTH(2), .LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .reset_n(reset_n),
        .word_in_valid(word_in_valid), .word_in_ready(ready_a),
        .word_in_data(word_in_data), .word_in_nbytes(word_in_nbytes),
        .stream_out_valid(valid_a), .stream_out_ready(stream_out_ready),
        .stream_out_data(data_a), .stream_out_last(last_a),
        .byte_count(bc_a), .err_count(ec_a)
    );

    sample_stream_serializer #(.WORD_BYTES(4), .FIFO_DEPTH(2), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .reset_n(reset_n),
        .word_in_valid(word_in_valid), .word_in_ready(ready_b),
        .word_in_data(word_in_data), .word_in_nbytes(word_in_nbytes),
        .stream_out_valid(valid_b), .stream_out_ready(stream_out_ready),
        .stream_out_data(data_b), .stream_out_last(last_b),
        .byte_count(bc_b), .err_count(ec_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_count++;
        assert (obs === exp) pass_count++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference: a word becomes a list of {last, byte} in send order for each byte order.
    task automatic model_word(input logic [31:0] d, input int n);
        if (n == 0 || n > 4) begin
            if (err_model < 255) err_model++;
        end else begin
            for (int i = 0; i < n; i++) begin
                q_lsb.push_back({i == n - 1, d[8*i +: 8]});
                q_msb.push_back({i == n - 1, d[8*(n-1-i) +: 8]});
            end
            bytes_model += n;
        end
    endtask

    task automatic mon(input int k, input logic v, input logic [7:0] d, input logic l);
        string      nm;
        logic [8:0] exp;
        nm = (k == 0) ? "lsb" : "msb";
        if (!v) chk({nm, "_last_without_valid"}, l, 1'b0);
        if (prev_stall[k]) begin
            chk({nm, "_hold_valid"}, v, 1'b1);
            chk({nm, "_hold_data"}, d, prev_data[k]);
            chk({nm, "_hold_last"}, l, prev_last[k]);
        end
        if (v && stream_out_ready) begin
            chk({nm, "_beat_expected"}, (k == 0) ? (q_lsb.size() > 0) : (q_msb.size() > 0), 1'b1);
            if ((k == 0 && q_lsb.size() > 0) || (k == 1 && q_msb.size() > 0)) begin
                exp = (k == 0) ? q_lsb.pop_front() : q_msb.pop_front();
                chk({nm, "_beat_data"}, d, exp[7:0]);
                chk({nm, "_beat_last"}, l, exp[8]);
            end
            if (k == 0) beats++;
        end
        prev_stall[k] = v && !stream_out_ready;
        prev_data[k]  = d;
        prev_last[k]  = l;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1) begin
                mon(0, valid_a, data_a, last_a);
                mon(1, valid_b, data_b, last_b);
            end else begin
                prev_stall[0] = 1'b0;
                prev_stall[1] = 1'b0;
            end
        end
    end

    initial begin
        stream_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            stream_out_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : rdy_const;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic push_word(input logic [31:0] d, input logic [2:0] n);
        int waited = 0;
        word_in_valid  = 1'b1;
        word_in_data   = d;
        word_in_nbytes = n;
        @(negedge clk);
        while (!ready_a && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        chk("push_ready", ready_a, 1'b1);
        @(posedge clk);
        #1;
        if (waited < 100) model_word(d, int'(n));
        word_in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int c = 0;
        rdy_rand  = 1'b0;
        rdy_const = 1'b1;
        while ((q_lsb.size() > 0 || q_msb.size() > 0 || valid_a || valid_b) && c < budget) begin
            @(posedge clk);
            c++;
        end
        #1;
        chk("drain_lsb_empty", q_lsb.size(), 0);
        chk("drain_msb_empty", q_msb.size(), 0);
        chk("byte_count_lsb", bc_a, bytes_model[31:0]);
        chk("byte_count_msb", bc_b, bytes_model[31:0]);
        chk("err_count_lsb", ec_a, err_model[7:0]);
        chk("err_count_msb", ec_b, err_model[7:0]);
    endtask

    logic pat[7];
    int   base;

    initial begin
        reset_n        = 1'b0;
        word_in_valid  = 1'b0;
        word_in_data   = '0;
        word_in_nbytes = '0;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", ready_a, 1'b0);
        chk("rst_valid", valid_a, 1'b0);
        chk("rst_data", data_a, 8'h00);
        chk("rst_last", last_a, 1'b0);
        chk("rst_byte_count", bc_a, 32'd0);
        chk("rst_err_count", ec_a, 8'd0);
        chk("rst_valid_msb", valid_b, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_release", ready_a, 1'b1);

        // Basic word with latency check
        push_word(32'hDDCCBBAA, 3'd4);
        chk("latency_valid_n0", valid_a, 1'b0);
        @(posedge clk); #1;
        chk("latency_valid_n1", valid_a, 1'b0);
        @(posedge clk); #1;
        chk("latency_valid_n2", valid_a, 1'b1);
        chk("first_byte_lsb", data_a, 8'hAA);
        chk("first_byte_msb", data_b, 8'hDD);
        drain(50);
        chk("basic_byte_count", bc_a, 32'd4);

        // Partial word
        push_word(32'h00003344, 3'd2);
        drain(50);

        // Backpressure pattern
        push_word(32'h04030201, 3'd4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 7; i++) begin
            rdy_const = pat[i];
            @(posedge clk); #1;
        end
        rdy_const = 1'b1;
        drain(50);

        // FIFO full, then contiguous release
        rdy_const = 1'b0;
        @(posedge clk); #1;
        push_word(32'h14131211, 3'd4);
        push_word(32'h24232221, 3'd4);
        push_word(32'h34333231, 3'd4);
        chk("full_ready_low", ready_a, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("full_ready_still_low", ready_a, 1'b0);
        rdy_const = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("contiguous_valid", valid_a, 1'b1);
        end
        drain(50);

        // Malformed words
        push_word(32'hDEADBEEF, 3'd0);
        push_word(32'hCAFEF00D, 3'd5);
        push_word(32'h00000011, 3'd1);
        drain(50);
        chk("malformed_err_count", ec_a, 8'd2);

        // Randomised traffic
        rdy_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            push_word($urandom, 3'($urandom_range(0, 6)));
        end
        drain(800);

        // Reset in the middle of a word
        rdy_const = 1'b1;
        base = beats;
        push_word(32'hA4A3A2A1, 3'd4);
        for (int i = 0; i < 20 && (beats - base) < 2; i++) begin
            @(posedge clk); #1;
        end
        chk("midword_two_beats", beats - base, 2);
        reset_n = 1'b0;
        #1;
        chk("midword_valid_lsb", valid_a, 1'b0);
        chk("midword_valid_msb", valid_b, 1'b0);
        chk("midword_byte_count", bc_a, 32'd0);
        chk("midword_err_count", ec_a, 8'd0);
        chk("midword_ready", ready_a, 1'b0);
        q_lsb.delete();
        q_msb.delete();
        bytes_model = 0;
        err_model   = 0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("no_residual_lsb", valid_a, 1'b0);
            chk("no_residual_msb", valid_b, 1'b0);
        end
        chk("post_reset_byte_count", bc_a, 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/sample_stream_serializer.md
Name: sample_stream_serializer

Overview:
- Upstream feeder for the byte-stream sample module.
- Accepts words of up to WORD_BYTES bytes on a valid/ready interface and buffers them in a small FIFO.
- Serialises each word into 8-bit beats on a valid/ready byte stream. That stream connects directly to the downstream byte input: data to stream_in_data, valid to stream_in_valid, ready from stream_in_ready.
- Flags the final byte of each word and keeps byte and error statistics for the bench.

Parameters:
- WORD_BYTES, 4: bytes per input word; 2..8.
- FIFO_DEPTH, 2: input word FIFO entries; power of two, ≥2.
- LSB_FIRST, 1: 1 = byte 0 (bits 7:0) sent first; 0 = most-significant valid byte sent first.

Ports:
- clk, input, 1: single clock, rising edge.
- reset_n, input, 1: reset, asynchronous and active-low.
- word_in_valid, input, 1: input word valid.
- word_in_ready, output, 1: FIFO can accept a word.
- word_in_data, input, 8*WORD_BYTES: word payload.
- word_in_nbytes, input, $clog2(WORD_BYTES+1): number of valid bytes, taken from the low end.
- stream_out_valid, output, 1: byte beat valid.
- stream_out_ready, input, 1: downstream accepts the beat.
- stream_out_data, output, 8: byte payload.
- stream_out_last, output, 1: beat is the final byte of its word.
- byte_count, output, 32: bytes transferred since reset.
- err_count, output, 8: malformed words dropped since reset.

Behaviour:
- Reset (async assert, sync deassert):
  - word_in_ready=0 while reset_n=0, then 1 from the first clock after release.
  - stream_out_valid=0, stream_out_data=0, stream_out_last=0.
  - byte_count=0, err_count=0; FIFO emptied; FSM in IDLE.
- Input handshake:
  - A transfer occurs when word_in_valid && word_in_ready at a rising edge.
  - word_in_ready = !fifo_full, driven from registered state only.
  - No combinational path from stream_out_ready to word_in_ready.
- Malformed words:
  - nbytes==0 or nbytes>WORD_BYTES: word is accepted but not written to the FIFO.
  - err_count increments and saturates at 255.
- FIFO:
  - Simultaneous push and pop is allowed whenever not full; count is unchanged.
  - No push-bypass: a push to an empty FIFO is visible to the serialiser on the next cycle.
- FSM states:
  - IDLE: if FIFO not empty, pop the head into the shift register and load remaining=nbytes → LOAD_OUT.
  - LOAD_OUT: drive stream_out_valid=1 with the current byte → SEND.
  - SEND, on valid && ready:
    - byte_count++ (wraps modulo 2^32); remaining--.
    - If remaining was 1: stream_out_last was 1 on that beat. If FIFO not empty, pop the next word and present its first byte the next cycle (back-to-back). Otherwise go to IDLE.
    - Otherwise shift by 8 in the LSB_FIRST direction.
  - For LSB_FIRST=0 the first byte sent is byte (nbytes-1).
- Latency: word accepted at edge N into an empty FIFO with an idle serialiser → first byte valid after edge N+2.
- Throughput: back-to-back words sustain one byte per cycle with no bubble between words.
- Output stability: while stream_out_valid && !stream_out_ready, stream_out_data and stream_out_last hold stable; valid never drops before acceptance.
- stream_out_last is asserted only together with stream_out_valid.
- Reset mid-word: all state is discarded immediately; partially sent words are lost; no further beats appear.

Decomposition:
- Package sample_stream_pkg:
  - byte_t (logic [7:0]).
  - Serialiser FSM state enum: IDLE, LOAD_OUT, SEND.
  - Function nbytes_valid(nbytes, WORD_BYTES).
  - Constant ERR_SAT=8'hFF.
- Sub-module sample_word_fifo: parameterised width/depth synchronous FIFO.
  - Ports: clk, reset_n, push, pop, din, dout, full, empty.
  - Stores {nbytes, data}.
- Serialiser FSM, shift register and counters live in the top module.

Test Plan:
- Basic word, LSB_FIRST=1, ready held 1: push 32'hDDCCBBAA, nbytes=4.
  → Beats AA, BB, CC, DD on consecutive cycles; last=1 only on DD; byte_count=4; first valid two edges after acceptance.
- Partial word: push 32'h00003344, nbytes=2.
  → Beats 44, 33; last on 33.
  - Same word with LSB_FIRST=0 → beats 33, 44.
- Backpressure: push 32'h04030201, nbytes=4; toggle stream_out_ready 1,0,0,1,0,1,1.
  → Data held stable during stalls; sequence exactly 01, 02, 03, 04; byte_count=4.
- FIFO full and back-to-back: push 3 words of nbytes=4 with stream_out_ready=0.
  → word_in_ready drops after the FIFO fills plus one word in the serialiser; release ready → 12 contiguous beats with no gap; last on beats 4, 8, 12.
- Malformed words: push nbytes=0, then nbytes=5, then a valid word 32'h11 with nbytes=1.
  → err_count=2; single beat 11 with last=1; byte_count=1.
- Mid-word reset: pull reset_n low after beat 2 of a 4-byte word.
  → stream_out_valid=0 immediately; counters=0; no residual beats after release.
